// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler
//   Frame sequencer for the multi-ADC acquisition path. A free-running period
//   counter produces one tick per frame period. Each accepted tick starts one
//   conversion per ADC (ADC0 first) on the shared SPI engine. When all ADCs are
//   done, the results go to the UART transmitter as one framed packet:
//     A5, {lo,hi} per ADC, then the XOR of all data bytes.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     enable, chan_sel          frame enable, ADC input channel (latched per frame)
//     conv_start/adc/chan       request to the SPI conversion engine
//     conv_done/data            result handshake from the SPI conversion engine
//     tx_start/data, tx_busy    byte handshake with the UART transmitter
//     frame_active, overrun,    status: busy, sticky dropped-tick flag,
//     conv_err, frame_count     sticky timeout flag, completed-frame counter
module adc_frame_scheduler #(
  parameter int NUM_ADC      = 8,
  parameter int CLK_HZ       = 25000000,
  parameter int SAMPLE_HZ    = 100,
  parameter int CONV_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  chan_sel,
  output logic        conv_start,
  output logic [2:0]  conv_adc,
  output logic [2:0]  conv_chan,
  input  logic        conv_done,
  input  logic [9:0]  conv_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        frame_active,
  output logic        overrun,
  output logic        conv_err,
  output logic [15:0] frame_count
);

  localparam int PERIOD    = CLK_HZ / SAMPLE_HZ;
  localparam int PCNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TOUT_W    = (CONV_TIMEOUT > 1) ? $clog2(CONV_TIMEOUT) : 1;
  localparam int NUM_BYTES = 2 * NUM_ADC + 2;
  localparam int PTR_W     = $clog2(NUM_BYTES);
  localparam int IDX_W     = (NUM_ADC > 1) ? $clog2(NUM_ADC) : 1;

  localparam logic [PCNT_W-1:0] LAST_CNT  = PCNT_W'(PERIOD - 1);
  localparam logic [TOUT_W-1:0] LAST_TOUT = TOUT_W'(CONV_TIMEOUT - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_ADC - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_TX_REQ  = 3'd3;
  localparam logic [2:0] S_TX_ACK  = 3'd4;
  localparam logic [2:0] S_TX_WAIT = 3'd5;

  logic [2:0]        r_state;
  logic [PCNT_W-1:0] r_pcnt;
  logic [TOUT_W-1:0] r_tcnt;
  logic [IDX_W-1:0]  r_idx;
  logic [PTR_W-1:0]  r_ptr;
  logic [9:0]        r_sample [NUM_ADC];
  logic              r_conv_start;
  logic [2:0]        r_conv_adc;
  logic [2:0]        r_conv_chan;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;
  logic              r_overrun;
  logic              r_conv_err;
  logic [15:0]       r_frame_count;

  logic              w_tick;
  logic [7:0]        w_pkt [NUM_BYTES];
  logic [7:0]        w_xor [NUM_ADC+1];

  assign w_tick = (r_pcnt == LAST_CNT) & enable;

  // Packet image built from the sample registers; the checksum is a running
  // XOR chain over both data bytes of every ADC.
  assign w_pkt[0] = 8'hA5;
  assign w_xor[0] = 8'h00;
  generate
    for (genvar gi = 0; gi < NUM_ADC; gi++) begin : g_pkt
      assign w_pkt[2*gi+1] = r_sample[gi][7:0];
      assign w_pkt[2*gi+2] = {6'b0, r_sample[gi][9:8]};
      assign w_xor[gi+1]   = w_xor[gi] ^ r_sample[gi][7:0] ^ {6'b0, r_sample[gi][9:8]};
    end
  endgenerate
  assign w_pkt[NUM_BYTES-1] = w_xor[NUM_ADC];

  // Period counter runs regardless of state or enable so the frame cadence
  // stays fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (r_pcnt == LAST_CNT) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_tcnt        <= '0;
      r_idx         <= '0;
      r_ptr         <= '0;
      r_conv_start  <= 1'b0;
      r_conv_adc    <= 3'd0;
      r_conv_chan   <= 3'd0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_overrun     <= 1'b0;
      r_conv_err    <= 1'b0;
      r_frame_count <= 16'd0;
      for (int i = 0; i < NUM_ADC; i++) r_sample[i] <= 10'd0;
    end else begin
      r_conv_start <= 1'b0;
      r_tx_start   <= 1'b0;
      // A tick during a frame is dropped; the frame itself carries on.
      if (w_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_conv_chan <= chan_sel;
            r_idx       <= '0;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_conv_start <= 1'b1;
          r_conv_adc   <= 3'(r_idx);
          r_tcnt       <= '0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          if (conv_done || (r_tcnt == LAST_TOUT)) begin
            if (conv_done) begin
              r_sample[r_idx] <= conv_data;
            end else begin
              r_sample[r_idx] <= 10'h3FF;
              r_conv_err      <= 1'b1;
            end
            if (r_idx == LAST_IDX) begin
              r_ptr   <= '0;
              r_state <= S_TX_REQ;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_START;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_TX_REQ: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_pkt[r_ptr];
            r_state    <= S_TX_ACK;
          end
        end
        S_TX_ACK: begin
          if (tx_busy) r_state <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          if (!tx_busy) begin
            if (r_ptr == LAST_PTR) begin
              r_frame_count <= r_frame_count + 16'd1;
              r_state       <= S_IDLE;
            end else begin
              r_ptr   <= r_ptr + 1'b1;
              r_state <= S_TX_REQ;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign conv_start   = r_conv_start;
  assign conv_adc     = r_conv_adc;
  assign conv_chan    = r_conv_chan;
  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign frame_active = (r_state != S_IDLE);
  assign overrun      = r_overrun;
  assign conv_err     = r_conv_err;
  assign frame_count  = r_frame_count;

endmodule
